// File: rtl/m16_frame_sequencer_if.sv
// Filler-side bus and captured word stream of the M16 frame sequencer.
// The sequencer is the master: it drives the strobe, the pointer and the captured stream.
interface m16_frame_sequencer_if;
    logic        bufGetWord;
    logic [10:0] bufRdPointer;
    logic [11:0] dataWordIn;
    logic        frameStart;
    logic [11:0] wordOut;
    logic        wordValid;

    modport master (
        output bufGetWord, bufRdPointer, frameStart, wordOut, wordValid,
        input  dataWordIn
    );

    modport slave (
        input  bufGetWord, bufRdPointer, frameStart, wordOut, wordValid,
        output dataWordIn
    );
endinterface

// File: rtl/m16_frame_sequencer.sv
// M16 frame sequencer: paces word strobes to the filler, walks the read pointer
// through each frame, counts groups and frames, and re-times the returned words.
module m16_frame_sequencer #(
    parameter int WORD_DIV    = 16,
    parameter int FRAME_WORDS = 2048,
    parameter int NUM_GRP     = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    m16_frame_sequencer_if.master bus,
    output logic [4:0]            numGrp,
    output logic [15:0]           frameCnt,
    output logic                  busy
);

    localparam logic [7:0]  DIV_LAST = 8'(WORD_DIV - 1);
    localparam logic [10:0] PTR_LAST = 11'(FRAME_WORDS - 1);
    localparam logic [4:0]  GRP_LAST = 5'(NUM_GRP);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [7:0]  divCnt;
    logic [10:0] rdPointer;
    logic        getWord;
    logic        frameStartReg;
    logic        capPending;
    logic        wordValidReg;
    logic [11:0] wordOutReg;
    logic        start;
    logic        wrap;
    logic        advanceGrp;
    logic        divLast;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A stop only takes effect at the edge that retires the strobe for the last word.
    always_comb begin
        stateNext  = state;
        start      = 1'b0;
        advanceGrp = 1'b0;
        wrap       = getWord && (rdPointer == PTR_LAST);
        divLast    = (state != IDLE) && (divCnt == DIV_LAST);
        case (state)
            IDLE: begin
                if (enable) begin
                    stateNext  = RUN;
                    start      = 1'b1;
                    advanceGrp = 1'b1;
                end
            end
            RUN: begin
                advanceGrp = wrap;
                if (!enable) begin
                    stateNext = STOPPING;
                end
            end
            STOPPING: begin
                if (enable) begin
                    stateNext  = RUN;
                    advanceGrp = wrap;
                end else if (wrap) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // The filler latches its word on the strobe edge; we take it one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            divCnt        <= '0;
            rdPointer     <= '0;
            getWord       <= 1'b0;
            frameStartReg <= 1'b0;
            capPending    <= 1'b0;
            wordValidReg  <= 1'b0;
            wordOutReg    <= '0;
            numGrp        <= '0;
            frameCnt      <= '0;
        end else begin
            if (state == IDLE || divLast) begin
                divCnt <= '0;
            end else begin
                divCnt <= divCnt + 8'd1;
            end

            getWord       <= divLast;
            frameStartReg <= divLast && (rdPointer == 11'd0);

            if (start || wrap) begin
                rdPointer <= '0;
            end else if (getWord) begin
                rdPointer <= rdPointer + 11'd1;
            end

            if (wrap) begin
                frameCnt <= frameCnt + 16'd1;
            end

            if (advanceGrp) begin
                numGrp <= (numGrp == GRP_LAST) ? 5'd1 : numGrp + 5'd1;
            end

            capPending   <= getWord;
            wordValidReg <= capPending;
            if (capPending) begin
                wordOutReg <= bus.dataWordIn;
            end
        end
    end

    assign bus.bufGetWord   = getWord;
    assign bus.bufRdPointer = rdPointer;
    assign bus.frameStart   = frameStartReg;
    assign bus.wordOut      = wordOutReg;
    assign bus.wordValid    = wordValidReg;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_m16_frame_sequencer.sv
// Bench for m16_frame_sequencer: scenario tasks plus a strobe-schedule reference model
// that predicts every output on every cycle.
module tb_m16_frame_sequencer;
    localparam int WORD_DIV     = 4;
    localparam int FRAME_WORDS  = 2048;
    localparam int NUM_GRP      = 3;
    localparam int FRAME_CYCLES = WORD_DIV * FRAME_WORDS;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic [4:0]  numGrp;
    logic [15:0] frameCnt;
    logic        busy;
    int          passCnt  = 0;
    int          totalCnt = 0;

    m16_frame_sequencer_if bus();

    m16_frame_sequencer #(
        .WORD_DIV   (WORD_DIV),
        .FRAME_WORDS(FRAME_WORDS),
        .NUM_GRP    (NUM_GRP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .bus     (bus),
        .numGrp  (numGrp),
        .frameCnt(frameCnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Filler: registers the word for the strobed pointer on the strobe edge.
    always @(posedge clk) begin
        if (!reset) bus.dataWordIn <= '0;
        else if (bus.bufGetWord) bus.dataWordIn <= {1'b0, bus.bufRdPointer[9:0], 1'b0};
    end

    function automatic int nextGrp(input int g);
        return (g >= NUM_GRP) ? 1 : g + 1;
    endfunction

    function automatic logic [47:0] outVec();
        return {bus.bufGetWord, bus.bufRdPointer, bus.frameStart, numGrp, frameCnt,
                busy, bus.wordValid, bus.wordOut};
    endfunction

    // Reference model: strobes land every WORD_DIV cycles after a start; each strobe
    // retires one word, and retiring the last word of a frame is a frame boundary.
    int          cyc = 0;
    int          nextStrobe = 0;
    int          mPtr = 0;
    int          mGrp = 0;
    int          mFrames = 0;
    bit          mActive = 0;
    bit          mStopping = 0;
    bit          mStrobe = 0;
    bit          wasActive = 0;
    bit          pend = 0;
    bit          eValid = 0;
    logic [10:0] pendPtr = '0;
    logic [11:0] eWord = '0;
    logic [47:0] expV;
    logic [47:0] actV;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            mActive = 0; mStopping = 0; mStrobe = 0; mPtr = 0; mGrp = 0; mFrames = 0;
            pend = 0; eValid = 0; eWord = '0;
        end else begin
            eValid = pend;
            if (pend) eWord = {1'b0, pendPtr[9:0], 1'b0};
            pend    = mStrobe;
            pendPtr = 11'(mPtr);
            wasActive = mActive;
            if (mStrobe) begin
                if (mPtr == FRAME_WORDS - 1) begin
                    mPtr    = 0;
                    mFrames = (mFrames + 1) % 65536;
                    if (mStopping && !enable) mActive = 0;
                    else mGrp = nextGrp(mGrp);
                end else begin
                    mPtr++;
                end
            end
            if (wasActive) begin
                mStopping = mActive && !enable;
            end else if (enable) begin
                mActive = 1; mStopping = 0; mPtr = 0;
                mGrp = nextGrp(mGrp);
                nextStrobe = cyc + WORD_DIV;
            end
            mStrobe = mActive && (cyc == nextStrobe);
            if (mStrobe) nextStrobe += WORD_DIV;
        end
        expV = {mStrobe, 11'(mPtr), (mStrobe && mPtr == 0), 5'(mGrp), 16'(mFrames),
                mActive, eValid, eWord};
        actV = outVec();
        totalCnt++;
        if (actV !== expV)
            $display("[TB] FAIL model_cycle %0d: got %h, expected %h", cyc, actV, expV);
        else passCnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // ptr < 0 means any strobe.
    task automatic waitStrobe(input int ptr, input int limit, output int waited, output bit found);
        found  = 0;
        waited = 0;
        while (!found && waited < limit) begin
            tick(1);
            waited++;
            if (bus.bufGetWord === 1'b1 && (ptr < 0 || bus.bufRdPointer === 11'(ptr))) found = 1;
        end
    endtask

    task automatic test_reset();
        logic [47:0] v;
        reset  = 1'b0;
        enable = 1'b0;
        tick(4);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            v = outVec();
            totalCnt++;
            if (v !== 48'd0) $display("[TB] FAIL reset_idle cycle %0d: got %h, expected 0", i, v);
            else passCnt++;
        end
    endtask

    task automatic test_first_strobe();
        int waited;
        bit found;
        enable = 1'b1;
        waitStrobe(-1, WORD_DIV + 8, waited, found);
        totalCnt++;
        if (!found || waited != WORD_DIV + 1)
            $display("[TB] FAIL first_strobe_delay: got %0d (found=%0d), expected %0d", waited, found, WORD_DIV + 1);
        else passCnt++;
        totalCnt++;
        if ({bus.bufRdPointer, bus.frameStart, numGrp, busy} !== {11'd0, 1'b1, 5'd1, 1'b1})
            $display("[TB] FAIL first_strobe_fields: got ptr=%0d fs=%b grp=%0d busy=%b, expected 0 1 1 1",
                     bus.bufRdPointer, bus.frameStart, numGrp, busy);
        else passCnt++;
        for (int k = 1; k <= 3; k++) begin
            waitStrobe(-1, WORD_DIV + 8, waited, found);
            totalCnt++;
            if (!found || waited != WORD_DIV || bus.bufRdPointer !== 11'(k) || bus.frameStart !== 1'b0)
                $display("[TB] FAIL cadence %0d: got gap=%0d ptr=%0d fs=%b, expected gap=%0d ptr=%0d fs=0",
                         k, waited, bus.bufRdPointer, bus.frameStart, WORD_DIV, k);
            else passCnt++;
        end
    endtask

    task automatic test_capture();
        int waited;
        bit found;
        logic [10:0] p;
        logic [11:0] want;
        for (int k = 0; k < 8; k++) begin
            waitStrobe(-1, WORD_DIV + 8, waited, found);
            p    = bus.bufRdPointer;
            want = {1'b0, p[9:0], 1'b0};
            tick(1);
            totalCnt++;
            if (!found || bus.wordValid !== 1'b0)
                $display("[TB] FAIL capture_early ptr %0d: got valid=%b, expected 0", p, bus.wordValid);
            else passCnt++;
            tick(1);
            totalCnt++;
            if (bus.wordValid !== 1'b1 || bus.wordOut !== want)
                $display("[TB] FAIL capture ptr %0d: got valid=%b word=%h, expected 1 %h", p, bus.wordValid, bus.wordOut, want);
            else passCnt++;
        end
    endtask

    task automatic test_frames();
        int waited;
        bit found;
        int wantGrp;
        for (int f = 1; f <= 3; f++) begin
            waitStrobe(FRAME_WORDS - 1, FRAME_CYCLES + 16, waited, found);
            waitStrobe(-1, WORD_DIV + 8, waited, found);
            wantGrp = (f % NUM_GRP) + 1;
            totalCnt++;
            if (!found || waited != WORD_DIV || bus.bufRdPointer !== 11'd0 || bus.frameStart !== 1'b1 ||
                frameCnt !== 16'(f) || numGrp !== 5'(wantGrp))
                $display("[TB] FAIL frame_wrap %0d: got found=%0d gap=%0d ptr=%0d fs=%b frames=%0d grp=%0d, expected gap=%0d ptr=0 fs=1 frames=%0d grp=%0d",
                         f, found, waited, bus.bufRdPointer, bus.frameStart, frameCnt, numGrp, WORD_DIV, f, wantGrp);
            else passCnt++;
        end
    endtask

    task automatic test_stop();
        int waited;
        bit found;
        int strobes;
        int busyCycles;
        waitStrobe(100, FRAME_CYCLES + 16, waited, found);
        enable = 1'b0;
        waitStrobe(FRAME_WORDS - 1, FRAME_CYCLES + 16, waited, found);
        totalCnt++;
        if (!found || busy !== 1'b1)
            $display("[TB] FAIL stop_last_strobe: got found=%0d busy=%b, expected 1 1", found, busy);
        else passCnt++;
        tick(1);
        totalCnt++;
        if ({busy, bus.bufGetWord, bus.bufRdPointer, frameCnt, numGrp} !== {1'b0, 1'b0, 11'd0, 16'd4, 5'd1})
            $display("[TB] FAIL stop_idle: got busy=%b stb=%b ptr=%0d frames=%0d grp=%0d, expected 0 0 0 4 1",
                     busy, bus.bufGetWord, bus.bufRdPointer, frameCnt, numGrp);
        else passCnt++;
        tick(1);
        totalCnt++;
        if (bus.wordValid !== 1'b1 || bus.wordOut !== 12'h7FE)
            $display("[TB] FAIL stop_last_word: got valid=%b word=%h, expected 1 7fe", bus.wordValid, bus.wordOut);
        else passCnt++;
        strobes    = 0;
        busyCycles = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (bus.bufGetWord !== 1'b0) strobes++;
            if (busy !== 1'b0) busyCycles++;
        end
        totalCnt++;
        if (strobes != 0 || busyCycles != 0)
            $display("[TB] FAIL stop_quiet: got strobes=%0d busy=%0d, expected 0 0", strobes, busyCycles);
        else passCnt++;
    endtask

    task automatic test_reraise();
        int waited;
        bit found;
        int r;
        int total;
        enable = 1'b1;
        waitStrobe(-1, WORD_DIV + 8, waited, found);
        totalCnt++;
        if (!found || bus.bufRdPointer !== 11'd0 || numGrp !== 5'd2)
            $display("[TB] FAIL restart: got found=%0d ptr=%0d grp=%0d, expected 1 0 2", found, bus.bufRdPointer, numGrp);
        else passCnt++;
        waitStrobe(100, FRAME_CYCLES + 16, waited, found);
        tick($urandom_range(0, WORD_DIV - 2));
        enable = 1'b0;
        waitStrobe(500, FRAME_CYCLES + 16, waited, found);
        r = $urandom_range(0, WORD_DIV - 2);
        tick(r);
        enable = 1'b1;
        waitStrobe(0, FRAME_CYCLES + 16, waited, found);
        total = r + waited;
        totalCnt++;
        if (!found || total != (FRAME_WORDS - 500) * WORD_DIV)
            $display("[TB] FAIL reraise_cadence: got %0d cycles (found=%0d), expected %0d", total, found, (FRAME_WORDS - 500) * WORD_DIV);
        else passCnt++;
        totalCnt++;
        if ({busy, numGrp, frameCnt} !== {1'b1, 5'd3, 16'd5})
            $display("[TB] FAIL reraise_counts: got busy=%b grp=%0d frames=%0d, expected 1 3 5", busy, numGrp, frameCnt);
        else passCnt++;
    endtask

    task automatic test_reset_midframe();
        int waited;
        bit found;
        logic [47:0] v;
        waitStrobe(700, FRAME_CYCLES + 16, waited, found);
        tick(WORD_DIV - 1);
        reset = 1'b0;
        tick(1);
        v = outVec();
        totalCnt++;
        if (!found || v !== 48'd0)
            $display("[TB] FAIL midframe_reset: got %h (found=%0d), expected 0", v, found);
        else passCnt++;
        reset = 1'b1;
        waitStrobe(-1, WORD_DIV + 8, waited, found);
        totalCnt++;
        if (!found || waited != WORD_DIV + 1 || bus.bufRdPointer !== 11'd0 || numGrp !== 5'd1 || frameCnt !== 16'd0)
            $display("[TB] FAIL midframe_restart: got gap=%0d ptr=%0d grp=%0d frames=%0d, expected %0d 0 1 0",
                     waited, bus.bufRdPointer, numGrp, frameCnt, WORD_DIV + 1);
        else passCnt++;
    endtask

    task automatic test_random_enable();
        int waited;
        for (int i = 0; i < 60; i++) begin
            enable = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 60));
        end
        enable = 1'b0;
        waited = 0;
        while (busy !== 1'b0 && waited < FRAME_CYCLES + 32) begin
            tick(1);
            waited++;
        end
        tick(4);
        totalCnt++;
        if (busy !== 1'b0 || bus.bufRdPointer !== 11'd0)
            $display("[TB] FAIL random_drain: got busy=%b ptr=%0d after %0d cycles, expected 0 0", busy, bus.bufRdPointer, waited);
        else passCnt++;
    endtask

    initial begin
        test_reset();
        test_first_strobe();
        test_capture();
        test_frames();
        test_stop();
        test_reraise();
        test_reset_midframe();
        test_random_enable();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
